instruction_fetch_stage: RTL

- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel; memory latency is variable.
- Buffers up to two returned instructions and presents the oldest one as the IF/ID input each cycle.
- On a redirect from `takebranch`, the PC jumps to the branch target and every stale in-flight response is squashed.

---
 rtl/instruction_fetch_stage_pkg.sv | 16 +
 rtl/instruction_fetch_stage_fifo.sv | 42 ++++
 rtl/instruction_fetch_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage types: opcode constants, fetch buffer entry and IF/ID bus layout.
package instruction_fetch_stage_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
  } if_id_bus_t;
endpackage

// File: rtl/instruction_fetch_stage_fifo.sv
// Two-entry synchronous FIFO of {pc, instr} with flush; head is always entry0.
module fetch_fifo
  import instruction_fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic [63:0] head
);
  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'(FETCH_DEPTH)) || do_pop);
  assign head    = entry0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_pop) begin
        entry0 <= (do_push && count == 2'd1) ? push_data : entry1;
        if (do_push && count == 2'd2) entry1 <= push_data;
      end else if (do_push) begin
        if (count == 2'd0) entry0 <= push_data;
        else entry1 <= push_data;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues word reads over valid/ready, buffers returns for IF/ID.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        takebranch,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid
);
  logic [31:0]  pc;
  logic [1:0]   inflight;
  logic [1:0]   discard;
  logic [1:0]   count;
  logic [1:0]   pend_count;
  logic [63:0]  head_raw;
  logic [63:0]  pend_raw;
  fetch_entry_t head;
  fetch_entry_t pend_head;
  if_id_bus_t   if_id;
  logic [2:0]   occupancy;
  logic         redirect;
  logic         req_fire;
  logic         resp_take;
  logic         resp_keep;
  logic         consume;
  logic         unused_bits;

  assign redirect  = takebranch && !stall;
  // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !reset && (occupancy < 3'(DEPTH)) && !redirect;
  assign imem_req_addr  = pc;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_take = imem_resp_valid && (inflight != 2'd0);
  assign resp_keep = resp_take && (discard == 2'd0) && !redirect;
  assign consume   = !stall && !takebranch && (count != 2'd0);
  assign head      = fetch_entry_t'(head_raw);
  assign pend_head = fetch_entry_t'(pend_raw);
  assign unused_bits = ^{pend_raw[31:0], pend_count, branch_target[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= 2'd0;
      discard  <= 2'd0;
    end else if (redirect) begin
      pc       <= {branch_target[31:2], 2'b00};
      inflight <= inflight - {1'b0, resp_take};
      discard  <= inflight - {1'b0, resp_take};
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      inflight <= inflight + {1'b0, req_fire} - {1'b0, resp_take};
      if (resp_take && discard != 2'd0) discard <= discard - 2'd1;
    end
  end

  fetch_fifo u_entries (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_keep),
    .push_data ({pend_head.pc, imem_resp_data}),
    .pop       (consume),
    .flush     (redirect),
    .count     (count),
    .head      (head_raw)
  );

  // Request PCs waiting for their data; the instr field is unused here.
  fetch_fifo u_pending (
    .clock     (clock),
    .reset     (reset),
    .push      (req_fire),
    .push_data ({pc, 32'h0}),
    .pop       (resp_keep),
    .flush     (redirect),
    .count     (pend_count),
    .head      (pend_raw)
  );

  assign if_id.valid       = (count != 2'd0);
  assign if_id.instruction = if_id.valid ? head.instr : NOP_INST;
  assign if_id.pc          = if_id.valid ? head.pc : 32'h0;
  assign fetch_valid       = if_id.valid;
  assign fetch_instruction = if_id.instruction;
  assign fetch_pc          = if_id.pc;

  assert property (@(posedge clock) disable iff (reset) imem_resp_valid |-> inflight != 2'd0);
endmodule
